// File: rtl/jpeg_fb_writer.sv
// Framebuffer sink for the decoder pixel stream: turns each in-range pixel into
// a word-aligned memory write (RGBX8888 or RGB565) and reports frame completion.
module jpeg_fb_writer #(
  parameter int unsigned PIXEL_FMT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_start_i,
  input  logic [31:0] cfg_base_i,
  input  logic [15:0] cfg_stride_i,
  input  logic        inport_valid_i,
  input  logic [15:0] inport_width_i,
  input  logic [15:0] inport_height_i,
  input  logic [15:0] inport_pixel_x_i,
  input  logic [15:0] inport_pixel_y_i,
  input  logic [7:0]  inport_pixel_r_i,
  input  logic [7:0]  inport_pixel_g_i,
  input  logic [7:0]  inport_pixel_b_i,
  output logic        inport_accept_o,
  output logic        wr_valid_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  input  logic        wr_accept_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [31:0] pixel_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q;
  logic [15:0] stride_q;
  logic [31:0] total_q;
  logic        first_q;
  logic [31:0] count_q;

  logic        s1_valid_q;
  logic        s1_in_range_q;
  logic [15:0] s1_x_q, s1_y_q;
  logic [7:0]  s1_r_q, s1_g_q, s1_b_q;

  logic        wr_valid_q;
  logic [31:0] wr_addr_q, wr_data_q;
  logic [3:0]  wr_strb_q;

  logic        s2_ready, s1_adv, in_fire, wr_fire;
  logic [31:0] count_inc, frame_total, byte_addr, pack_data;
  logic [15:0] pix16;
  logic [3:0]  pack_strb;

  // Out-of-range pixels leave stage 1 even when stage 2 is stalled,
  // since they never occupy the write stage.
  assign s2_ready        = !wr_valid_q || wr_accept_i;
  assign s1_adv          = s1_valid_q && (!s1_in_range_q || s2_ready);
  assign inport_accept_o = (state_q == ST_RUN) && (!s1_valid_q || s1_adv);
  assign in_fire         = inport_valid_i && inport_accept_o;
  assign wr_fire         = wr_valid_q && wr_accept_i;
  assign count_inc       = count_q + 32'd1;
  assign frame_total     = 32'(inport_width_i) * 32'(inport_height_i);

  always_comb begin
    byte_addr = base_q + 32'(s1_y_q) * 32'(stride_q)
              + ((PIXEL_FMT == 1) ? {15'd0, s1_x_q, 1'b0} : {14'd0, s1_x_q, 2'b00});
    pix16     = {s1_r_q[7:3], s1_g_q[7:2], s1_b_q[7:3]};
    pack_data = {8'h00, s1_r_q, s1_g_q, s1_b_q};
    pack_strb = 4'hF;
    if (PIXEL_FMT == 1) begin
      pack_data = {pix16, pix16};
      pack_strb = byte_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cfg_start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (in_fire && first_q && (frame_total == '0)) begin
          state_d = ST_DONE;
        end else if (wr_fire && !first_q && (count_inc == total_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (!s1_valid_q && !wr_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      stride_q      <= '0;
      total_q       <= '0;
      first_q       <= 1'b0;
      count_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_in_range_q <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_r_q        <= '0;
      s1_g_q        <= '0;
      s1_b_q        <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_strb_q     <= '0;
    end else begin
      state_q <= state_d;

      if (wr_fire) count_q <= count_inc;
      if ((state_q == ST_IDLE) && cfg_start_i) begin
        base_q   <= cfg_base_i;
        stride_q <= cfg_stride_i;
        count_q  <= '0;
        first_q  <= 1'b1;
      end
      if (in_fire && first_q) begin
        total_q <= frame_total;
        first_q <= 1'b0;
      end

      if (in_fire) begin
        s1_valid_q    <= 1'b1;
        s1_in_range_q <= (inport_pixel_x_i < inport_width_i) &&
                         (inport_pixel_y_i < inport_height_i);
        s1_x_q        <= inport_pixel_x_i;
        s1_y_q        <= inport_pixel_y_i;
        s1_r_q        <= inport_pixel_r_i;
        s1_g_q        <= inport_pixel_g_i;
        s1_b_q        <= inport_pixel_b_i;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_ready) begin
        wr_valid_q <= s1_valid_q && s1_in_range_q;
        if (s1_valid_q && s1_in_range_q) begin
          wr_addr_q <= byte_addr & ~32'h3;
          wr_data_q <= pack_data;
          wr_strb_q <= pack_strb;
        end
      end
    end
  end

  assign wr_valid_o    = wr_valid_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign wr_strb_o     = wr_strb_q;
  assign busy_o        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign frame_done_o  = (state_q == ST_DONE);
  assign pixel_count_o = count_q;

endmodule
